// File: rtl/crypto_stream_pkg.sv
// Shared widths and word/block types for the crypto stream block builder and splitter.
package crypto_stream_pkg;

   localparam int unsigned CS_WORD_W  = 32;
   localparam int unsigned CS_WORDS   = 4;
   localparam int unsigned CS_BLOCK_W = CS_WORD_W * CS_WORDS;

   typedef logic [CS_WORD_W-1:0]  word_t;
   typedef logic [CS_BLOCK_W-1:0] block_t;

   // Width of a counter able to hold 0..words inclusive.
   function automatic int unsigned cnt_width(input int unsigned words);
      return (words < 1) ? 1 : $clog2(words + 1);
   endfunction

endpackage

// File: rtl/be_block_splitter.sv
// Splits a big-endian block into WORDS words, word 0 first, with valid/ready on both sides.
// Define BE_SPLITTER_PREFETCH_EN to accept the next block on the last-word edge (no bubble).
module be_block_splitter
   import crypto_stream_pkg::*;
#(
   parameter  int unsigned WORD_W  = CS_WORD_W,
   parameter  int unsigned WORDS   = CS_WORDS,
   localparam int unsigned BLOCK_W = WORD_W * WORDS
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               block_valid,
   output logic               block_ready,
   input  logic [BLOCK_W-1:0] block,
   output logic               word_valid,
   input  logic               word_ready,
   output logic [WORD_W-1:0]  word,
   output logic               word_last
);

   localparam int unsigned CNT_W = cnt_width(WORDS);

   logic [CNT_W-1:0]   count;
   logic [CNT_W-1:0]   count_nxt;
   logic [BLOCK_W-1:0] shreg;
   logic [BLOCK_W-1:0] shreg_nxt;
   logic               word_xfer_c;
   logic               block_xfer_c;

   // Ready is a function of occupancy (and downstream ready when prefetching), never of block_valid.
   always_comb begin
      block_ready = (count == '0);
`ifdef BE_SPLITTER_PREFETCH_EN
      if ((count == CNT_W'(1)) && word_ready) begin
         block_ready = 1'b1;
      end
`endif
   end

   assign word_xfer_c  = word_valid && word_ready;
   assign block_xfer_c = block_valid && block_ready;

   // A block load overrides the shift so a prefetched block lands intact.
   always_comb begin
      count_nxt = count;
      shreg_nxt = shreg;
      if (word_xfer_c) begin
         count_nxt = count - CNT_W'(1);
         shreg_nxt = shreg << WORD_W;
      end
      if (block_xfer_c) begin
         count_nxt = CNT_W'(WORDS);
         shreg_nxt = block;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count      <= '0;
         shreg      <= '0;
         word_valid <= 1'b0;
         word_last  <= 1'b0;
      end else begin
         count      <= count_nxt;
         shreg      <= shreg_nxt;
         word_valid <= (count_nxt != '0);
         word_last  <= (count_nxt == CNT_W'(1));
      end
   end

   assign word = shreg[BLOCK_W-1 -: WORD_W];

endmodule

// File: tb/tb_be_block_splitter.sv
// Bench for be_block_splitter: queue-based word model checked every cycle plus directed literal checks.
module tb_be_block_splitter;

   logic         clk;
   logic         rst;
   logic         block_valid;
   logic         block_ready;
   logic [127:0] block;
   logic         word_valid;
   logic         word_ready;
   logic [31:0]  word;
   logic         word_last;

   be_block_splitter dut (
      .clk         (clk),
      .rst         (rst),
      .block_valid (block_valid),
      .block_ready (block_ready),
      .block       (block),
      .word_valid  (word_valid),
      .word_ready  (word_ready),
      .word        (word),
      .word_last   (word_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct { logic [31:0] w; logic last; } mw_t;
   typedef struct { logic [31:0] w; logic last; int cyc; } le_t;

   mw_t m_q[$];
   le_t log_q[$];
   int  cyc     = 0;
   int  n_tests = 0;
   int  n_fail  = 0;
   bit  chk_en  = 0;

`ifdef BE_SPLITTER_PREFETCH_EN
   localparam bit PREFETCH = 1'b1;
`else
   localparam bit PREFETCH = 1'b0;
`endif

   localparam logic [127:0] BLK_A = 128'h0123456789ABCDEFA0A0A0A0F9F9F9F9;
   localparam logic [127:0] BLK_B = 128'h76543210FEDCBA98B1B1B1B1E8E8E8E8;

   logic [31:0] exp_a [4];
   logic [31:0] exp_b [4];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Model readiness: empty, or (prefetch) holding only the last word which leaves this edge.
   function automatic logic m_ready();
      return (m_q.size() == 0) || (PREFETCH && m_q.size() == 1 && word_ready);
   endfunction

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Model: the words still owed downstream, in output order.
   initial forever begin
      logic wx;
      logic bx;
      @(posedge clk);
      if (rst) begin
         m_q.delete();
      end else begin
         wx = (m_q.size() != 0) && word_ready;
         bx = block_valid && m_ready();
         if (wx) void'(m_q.pop_front());
         if (bx) begin
            for (int i = 0; i < 4; i++) begin
               m_q.push_back('{block[127-32*i -: 32], (i == 3)});
            end
         end
      end
   end

   // Per-cycle compare against the model, plus a log of accepted words for directed checks.
   initial forever begin
      @(negedge clk);
      if (chk_en && !rst) begin
         check("word_valid", 128'(word_valid), 128'(m_q.size() != 0));
         check("block_ready", 128'(block_ready), 128'(m_ready()));
         if (m_q.size() != 0) begin
            check("word", 128'(word), 128'(m_q[0].w));
            check("word_last", 128'(word_last), 128'(m_q[0].last));
         end else begin
            check("word_idle", 128'(word), 128'(0));
            check("word_last_idle", 128'(word_last), 128'(0));
         end
      end
      if (word_valid && word_ready && !rst) log_q.push_back('{word, word_last, cyc});
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Offer a block until accepted; acc is the cycle count at the accepting edge.
   task automatic send_block(input logic [127:0] b, output int acc);
      logic r;
      block       = b;
      block_valid = 1'b1;
      acc         = -1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         r = block_ready;
         @(posedge clk);
         #1;
         if (r) begin
            acc = cyc;
            break;
         end
      end
      block_valid = 1'b0;
      if (acc < 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL send_block_timeout: block %0h never accepted", b);
      end
   endtask

   task automatic check_block_log(input string name, input int base, input logic [31:0] ew [4]);
      for (int i = 0; i < 4; i++) begin
         check({name, "_word"}, 128'(log_q[base+i].w), 128'(ew[i]));
         check({name, "_last"}, 128'(log_q[base+i].last), 128'(i == 3));
      end
   endtask

   initial begin
      int acc;
      int acc2;
      exp_a = '{32'h01234567, 32'h89ABCDEF, 32'hA0A0A0A0, 32'hF9F9F9F9};
      exp_b = '{32'h76543210, 32'hFEDCBA98, 32'hB1B1B1B1, 32'hE8E8E8E8};
      rst = 1'b1; block_valid = 1'b0; block = '0; word_ready = 1'b1;
      step(3);
      rst = 1'b0;
      chk_en = 1'b1;

      // Reset state
      @(negedge clk);
      check("rst_word_valid", 128'(word_valid), 128'(0));
      check("rst_word_last", 128'(word_last), 128'(0));
      check("rst_word", 128'(word), 128'(0));
      check("rst_block_ready", 128'(block_ready), 128'(1));
      step(1);

      // Basic: four words on consecutive cycles, first one cycle after acceptance
      log_q.delete();
      send_block(BLK_A, acc);
      step(8);
      check("basic_count", 128'(log_q.size()), 128'(4));
      if (log_q.size() == 4) begin
         check_block_log("basic", 0, exp_a);
         check("basic_first_lat", 128'(log_q[0].cyc - acc), 128'(0));
         for (int i = 1; i < 4; i++) check("basic_spacing", 128'(log_q[i].cyc - log_q[i-1].cyc), 128'(1));
      end

      // Backpressure on word 1 for three cycles
      log_q.delete();
      send_block(BLK_A, acc);
      step(1);
      word_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("bp_word", 128'(word), 128'(32'h89ABCDEF));
         check("bp_valid", 128'(word_valid), 128'(1));
         check("bp_block_ready", 128'(block_ready), 128'(0));
         @(posedge clk);
         #1;
      end
      word_ready = 1'b1;
      step(6);
      check("bp_count", 128'(log_q.size()), 128'(4));
      if (log_q.size() == 4) begin
         check_block_log("bp", 0, exp_a);
         check("bp_stall_gap", 128'(log_q[1].cyc - log_q[0].cyc), 128'(4));
      end

      // Back-to-back blocks
      log_q.delete();
      send_block(BLK_A, acc);
      send_block(BLK_B, acc2);
      step(12);
      check("b2b_accept_gap", 128'(acc2 - acc), 128'(PREFETCH ? 4 : 5));
      check("b2b_count", 128'(log_q.size()), 128'(8));
      if (log_q.size() == 8) begin
         check_block_log("b2b_a", 0, exp_a);
         check_block_log("b2b_b", 4, exp_b);
         for (int i = 1; i < 8; i++)
            check("b2b_spacing", 128'(log_q[i].cyc - log_q[i-1].cyc), 128'((i == 4 && !PREFETCH) ? 2 : 1));
      end

      // Reset after the second word, with a block offered during reset
      log_q.delete();
      send_block(BLK_A, acc);
      step(2);
      rst = 1'b1;
      block = BLK_B;
      block_valid = 1'b1;
      step(1);
      rst = 1'b0;
      block_valid = 1'b0;
      @(negedge clk);
      check("mrst_word_valid", 128'(word_valid), 128'(0));
      check("mrst_block_ready", 128'(block_ready), 128'(1));
      check("mrst_word", 128'(word), 128'(0));
      check("mrst_words_before", 128'(log_q.size()), 128'(2));
      @(posedge clk);
      #1;
      log_q.delete();
      send_block(BLK_B, acc);
      step(8);
      check("mrst_next_count", 128'(log_q.size()), 128'(4));
      if (log_q.size() == 4) check_block_log("mrst_next", 0, exp_b);

      // Random valid/ready stalls, model checked every cycle
      for (int i = 0; i < 600; i++) begin
         block_valid = 1'($urandom_range(0, 1));
         block       = {$urandom(), $urandom(), $urandom(), $urandom()};
         word_ready  = ($urandom_range(0, 3) != 0);
         step(1);
      end
      block_valid = 1'b0;
      word_ready  = 1'b1;
      step(10);
      check("drain_idle", 128'(word_valid), 128'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1);
   end

endmodule

// File: doc/be_block_splitter.md
BE_BLOCK_SPLITTER -- requirements
Module: be_block_splitter

Interface
REQ-001 Parameter WORD_W, default 32, SHALL set the width of one output word in bits.
REQ-002 Parameter WORDS, default 4, SHALL set the number of words per block; BLOCK_W = WORD_W*WORDS (128 by default).
REQ-003 clk  input  1  SHALL be the single clock; every register is clocked on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: synchronous and active-high.
REQ-005 block_valid  input  1  SHALL indicate that the upstream block is valid.
REQ-006 block_ready  output  1  SHALL indicate that the splitter accepts a block this cycle.
REQ-007 block  input  BLOCK_W  SHALL carry the block, with word 0 in the MSBs ([127:96] by default).
REQ-008 word_valid  output  1  SHALL indicate that word is valid.
REQ-009 word_ready  input  1  SHALL indicate that the downstream stage accepts word this cycle.
REQ-010 word  output  WORD_W  SHALL carry the current word.
REQ-011 word_last  output  1  SHALL be high with the final word (index WORDS-1) of each block.

Function
REQ-012 A block transfer SHALL occur on a rising edge where block_valid && block_ready; a word transfer SHALL occur on a rising edge where word_valid && word_ready.
REQ-013 On a block transfer, the block SHALL be latched into a shift register and the remaining-word count set to WORDS.
REQ-014 word_valid SHALL equal (count != 0): a registered output, with latency 1 cycle from block transfer to first word.
REQ-015 word SHALL always drive the top WORD_W bits of the shift register, so words leave MSB-first: block[127:96], [95:64], [63:32], [31:0].
REQ-016 On each word transfer, the register SHALL shift left by WORD_W (zero fill) and count SHALL decrement by 1.
REQ-017 word_last SHALL equal (count == 1).
REQ-018 word and word_valid SHALL hold stable while word_valid && !word_ready (no retraction, no data change).
REQ-019 Without prefetch (see REQ-026), block_ready SHALL equal (count == 0), and the cycle after the last word SHALL be a bubble.
REQ-020 block_ready SHALL not depend combinationally on block_valid.
REQ-021 count SHALL never exceed WORDS; a block transfer with count already nonzero SHALL be impossible except in the REQ-026 case.

Reset
REQ-022 While rst is high at a rising edge, count SHALL become 0 and the shift register 0, giving word_valid=0, word_last=0, word=0.
REQ-023 block_ready SHALL be 1 in the cycle after reset releases.
REQ-024 A reset asserted mid-block SHALL discard the remaining words; no partial word SHALL appear after reset.
REQ-025 A block offered during a reset cycle SHALL not be captured.

Configuration
REQ-026 With BE_SPLITTER_PREFETCH_EN defined, block_ready SHALL equal (count == 0) || (count == 1 && word_ready), so a block accepted on the last-word edge reloads the register and count = WORDS with no bubble (sustained 1 word/cycle). Without the macro, REQ-019 applies.

Structure
REQ-027 Package crypto_stream_pkg SHALL hold the WORD_W/WORDS/BLOCK_W defaults and the word/block typedefs, shared with be_block_builder.
REQ-028 The block SHALL be a single module with no sub-module; the counter and shift register SHALL be inline.

Verification
REQ-029 Basic: block 0123456789ABCDEFA0A0A0A0F9F9F9F9 with word_ready=1 -> words 01234567, 89ABCDEF, A0A0A0A0, F9F9F9F9 on consecutive cycles, starting 1 cycle after acceptance; word_last only with F9F9F9F9.
REQ-030 Backpressure: word_ready low for 3 cycles on word 89ABCDEF -> word stays 89ABCDEF with valid high, and block_ready stays 0 throughout.
REQ-031 Back-to-back: blocks A then 76543210FEDCBA98B1B1B1B1E8E8E8E8 with both sides ready -> 8 words in order; 8 consecutive cycles with PREFETCH_EN, one bubble before 76543210 without it.
REQ-032 Reset mid-block: rst pulsed after the second word -> word_valid=0 next cycle, block_ready=1, and the next block starts fresh at its word 0.
REQ-033 Loopback: chain be_block_builder -> be_block_splitter with random valid/ready stalls, 1000 words -> output word stream identical to the input stream.
